// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - SISC instruction fetch, program counter and status unit
//
// Holds the PC, the instruction register and the status register. A single
// outstanding instruction read runs over a req/ack handshake, and the decoded
// IR fields are presented to the control FSM.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a read watchdog and the
// sticky fetch_err output.
//
// Ports:
//   clk, rst_f                 clock (rising edge), async active-low reset
//   ir_load                    start an instruction read at the current PC
//   pc_write, pc_sel, br_sel   PC update strobe and source selects
//   stat_en, stat_in           status register load strobe and value
//   mem_req, mem_addr          read request / registered read address
//   mem_ack, mem_rdata         read data valid / read data
//   instr, opcode, mm, imm     IR and its fixed-position fields
//   stat, pc                   status register, program counter
//   fetch_busy                 high while a read is outstanding
//   fetch_err                  (FETCH_TIMEOUT_EN only) sticky read-timeout flag

module sisc_fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               ir_load,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               stat_en,
  input  logic [3:0]         stat_in,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [3:0]         stat,
  output logic [PC_W-1:0]    pc,
`ifdef FETCH_TIMEOUT_EN
  output logic               fetch_err,
`endif
  output logic               fetch_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [INSTR_W-1:0] ir, ir_n;
  logic               req_n;
  logic [PC_W-1:0]    addr_n;
  logic               busy_n;
  logic [PC_W-1:0]    pc_n;
  logic [3:0]         stat_n;

  // Branch operands derived from the IR immediate field.
  logic [PC_W-1:0]    imm_zext;
  logic [PC_W-1:0]    imm_sext;

`ifdef FETCH_TIMEOUT_EN
  // The read is abandoned on the edge at which the wait counter would reach
  // 15, so mem_req is high for exactly 15 cycles when no ack ever arrives.
  localparam logic [3:0] TIMEOUT_LAST = 4'd14;

  logic [3:0] wait_cnt, wait_cnt_n;
  logic       err_n;
`endif

  // IR field slices
  assign instr  = ir;
  assign opcode = ir[INSTR_W-1:INSTR_W-4];
  assign mm     = ir[INSTR_W-5:INSTR_W-8];
  assign imm    = ir[15:0];

  assign imm_zext = PC_W'(imm);
  assign imm_sext = PC_W'($signed(imm));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= IDLE;
      ir         <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      fetch_busy <= 1'b0;
      pc         <= RESET_PC;
      stat       <= 4'd0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= 4'd0;
      fetch_err  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      ir         <= ir_n;
      mem_req    <= req_n;
      mem_addr   <= addr_n;
      fetch_busy <= busy_n;
      pc         <= pc_n;
      stat       <= stat_n;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= wait_cnt_n;
      fetch_err  <= err_n;
`endif
    end
  end

  // Fetch FSM: next state and handshake outputs
  always_comb begin
    state_n = state;
    ir_n    = ir;
    req_n   = mem_req;
    addr_n  = mem_addr;
    busy_n  = fetch_busy;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
    err_n      = fetch_err;
`endif

    case (state)
      IDLE: begin
        // A late ack arriving here is deliberately ignored.
        if (ir_load) begin
          state_n = WAIT;
          req_n   = 1'b1;
          addr_n  = pc;      // old PC even if pc_write fires on this edge
          busy_n  = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_n = 4'd0;
`endif
        end
      end

      WAIT: begin
        // ir_load is ignored here; there is no request queue.
        if (mem_ack) begin
          state_n = IDLE;
          ir_n    = mem_rdata;
          req_n   = 1'b0;
          busy_n  = 1'b0;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          // Abort: IR becomes NOOP so the control FSM does nothing harmful.
          state_n = IDLE;
          ir_n    = '0;
          req_n   = 1'b0;
          busy_n  = 1'b0;
          err_n   = 1'b1;
          wait_cnt_n = wait_cnt + 4'd1;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
`endif
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Program counter and status register; independent of the fetch FSM.
  always_comb begin
    pc_n   = pc;
    stat_n = stat;

    if (pc_write) begin
      if (!pc_sel) begin
        pc_n = pc + PC_W'(1);
      end else if (!br_sel) begin
        pc_n = imm_zext;
      end else begin
        pc_n = pc + imm_sext;
      end
    end

    if (stat_en) begin
      stat_n = stat_in;
    end
  end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb/tb_sisc_fetch_unit.sv - directed self-checking bench for sisc_fetch_unit

module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        stat_en;
  logic [3:0]  stat_in;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [3:0]  stat;
  logic [15:0] pc;
  logic        fetch_busy;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int tests;
  int fails;

  sisc_fetch_unit #(
    .PC_W    (16),
    .INSTR_W (32),
    .RESET_PC(16'h0000)
  ) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .stat_en   (stat_en),
    .stat_in   (stat_in),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .instr     (instr),
    .opcode    (opcode),
    .mm        (mm),
    .imm       (imm),
    .stat      (stat),
    .pc        (pc),
`ifdef FETCH_TIMEOUT_EN
    .fetch_err (fetch_err),
`endif
    .fetch_busy(fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] d);
    ir_load = 1'b1;
    step();
    ir_load   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = d;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic branch_abs();
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    step();
    pc_write = 1'b0;
  endtask

  int hi_cnt;

  initial begin
    tests = 0;
    fails = 0;
    rst_f = 1'b0; ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    stat_en = 1'b0; stat_in = 4'd0; mem_ack = 1'b0; mem_rdata = '0;

    // 1. reset and single zero-wait fetch
    step(); step();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_stat", 32'(stat), 32'h0);
`ifdef FETCH_TIMEOUT_EN
    check("rst_err", 32'(fetch_err), 32'h0);
`endif
    rst_f = 1'b1;
    step();
    ir_load = 1'b1;
    step();
    check("f1_req", 32'(mem_req), 32'h1);
    check("f1_addr", 32'(mem_addr), 32'h0);
    check("f1_busy", 32'(fetch_busy), 32'h1);
    check("f1_ir_hold", instr, 32'h0);
    ir_load = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h8123_0004;
    step();
    mem_ack = 1'b0;
    check("f1_opcode", 32'(opcode), 32'h8);
    check("f1_mm", 32'(mm), 32'h1);
    check("f1_imm", 32'(imm), 32'h0004);
    check("f1_req_low", 32'(mem_req), 32'h0);
    check("f1_busy_low", 32'(fetch_busy), 32'h0);

    // 2. three wait states, second ir_load ignored
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1 && fetch_busy === 1'b1 && mem_addr === 16'h0) hi_cnt++;
      ir_load = (i == 1);
      mem_ack = (i == 3);
      mem_rdata = 32'h5A6B_1111;
      step();
    end
    ir_load = 1'b0; mem_ack = 1'b0;
    check("w_high_cycles", 32'(hi_cnt), 32'd4);
    check("w_instr", instr, 32'h5A6B_1111);
    check("w_req_low", 32'(mem_req), 32'h0);
    step();
    check("w_no_requeue", 32'(mem_req), 32'h0);

    // 3. PC arithmetic
    do_fetch(32'h0000_FFFF);
    branch_abs();
    check("pc_abs_ffff", 32'(pc), 32'hFFFF);
    pc_write = 1'b1; pc_sel = 1'b0;
    step();
    pc_write = 1'b0;
    check("pc_wrap", 32'(pc), 32'h0000);
    do_fetch(32'h0000_0010);
    branch_abs();
    check("pc_abs_10", 32'(pc), 32'h0010);
    do_fetch(32'h0000_FFFC);
    check("pc_hold_fetch", 32'(pc), 32'h0010);
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    step();
    pc_write = 1'b0;
    check("pc_rel_neg", 32'(pc), 32'h000C);
    do_fetch(32'h0000_1234);
    branch_abs();
    check("pc_abs_1234", 32'(pc), 32'h1234);
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    step();
    pc_write = 1'b0;
    check("pc_rel_pos", 32'(pc), 32'h2468);

    // 4. simultaneous ir_load + pc_write, then pc_write during WAIT
    do_fetch(32'h0000_0005);
    branch_abs();
    check("pc_5", 32'(pc), 32'h0005);
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    step();
    ir_load = 1'b0;
    check("sim_addr", 32'(mem_addr), 32'h0005);
    check("sim_pc", 32'(pc), 32'h0006);
    step();
    pc_write = 1'b0;
    check("wait_pc", 32'(pc), 32'h0007);
    check("wait_addr", 32'(mem_addr), 32'h0005);
    check("wait_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h3000_0000;
    step();
    mem_ack = 1'b0;
    check("sim_opcode", 32'(opcode), 32'h3);

    // 5. status register and reset during a read
    stat_en = 1'b1; stat_in = 4'hA;
    step();
    stat_en = 1'b0; stat_in = 4'h5;
    check("stat_load", 32'(stat), 32'hA);
    step();
    check("stat_hold", 32'(stat), 32'hA);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    check("r_req_before", 32'(mem_req), 32'h1);
    rst_f = 1'b0;
    #1;
    check("r_req_async", 32'(mem_req), 32'h0);
    check("r_stat_async", 32'(stat), 32'h0);
    check("r_opcode_async", 32'(opcode), 32'h0);
    check("r_pc_async", 32'(pc), 32'h0);
    step();
    rst_f = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    check("late_ack_ir", instr, 32'h0);
    check("late_ack_req", 32'(mem_req), 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // 6. read timeout
    do_fetch(32'h9000_0000);
    check("to_pre_opcode", 32'(opcode), 32'h9);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      hi_cnt++;
      step();
    end
    check("to_req_cycles", 32'(hi_cnt), 32'd15);
    check("to_err", 32'(fetch_err), 32'h1);
    check("to_opcode", 32'(opcode), 32'h0);
    check("to_busy", 32'(fetch_busy), 32'h0);
    do_fetch(32'h7000_0000);
    check("to_refetch", 32'(opcode), 32'h7);
    check("to_err_sticky", 32'(fetch_err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
